// File: rtl/seg_pkg.sv
// Shared seven-segment constants and encoder for the display blocks.
package seg_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned SEG_OUT_W = 9;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // gfedcba, active-high; anything outside 0..9 is blanked
  function automatic logic [SEG_W-1:0] seg7_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg7_enc = SEG_0;
      4'd1:    seg7_enc = SEG_1;
      4'd2:    seg7_enc = SEG_2;
      4'd3:    seg7_enc = SEG_3;
      4'd4:    seg7_enc = SEG_4;
      4'd5:    seg7_enc = SEG_5;
      4'd6:    seg7_enc = SEG_6;
      4'd7:    seg7_enc = SEG_7;
      4'd8:    seg7_enc = SEG_8;
      4'd9:    seg7_enc = SEG_9;
      default: seg7_enc = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/segment_timer_if.sv
// Button inputs and display outputs of the segment timer.
interface segment_timer_if #(
  parameter int unsigned LED_W = 8
);
  import seg_pkg::*;

  logic                 hold;
  logic                 clear;
  logic                 dir;
  logic [SEG_OUT_W-1:0] seg_led_1;
  logic [SEG_OUT_W-1:0] seg_led_2;
  logic [LED_W-1:0]     led;
  logic                 running;
  logic                 done;

  modport master (
    output hold, clear, dir,
    input  seg_led_1, seg_led_2, led, running, done
  );

  modport slave (
    input  hold, clear, dir,
    output seg_led_1, seg_led_2, led, running, done
  );

endinterface

// File: rtl/bcd_digit.sv
// One mod-N up/down digit with synchronous load and a carry/borrow flag.
module bcd_digit #(
  parameter  int unsigned N = 10,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         wrap_out_c
);

  // Carry on the last step up, borrow on the step below zero
  assign wrap_out_c = (inc && (q == W'(N - 1))) || (dec && (q == '0));

  // Digit register: load beats inc, inc beats dec
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= (q == W'(N - 1)) ? '0 : q + W'(1);
    end else if (dec) begin
      q <= (q == '0) ? W'(N - 1) : q - W'(1);
    end
  end

endmodule

// File: rtl/segment_timer.sv
// mm:ss up/down timer with 7-seg seconds and an active-low minute LED bar.
module segment_timer
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned MAX_MIN = 8,
  parameter int unsigned LED_W   = 8,
  parameter bit          WRAP    = 1'b0
) (
  input logic            clk,
  input logic            rst,
  segment_timer_if.slave bus
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned MIN_W = $clog2(MAX_MIN + 1);
  localparam int unsigned SU_W  = $clog2(10);
  localparam int unsigned ST_W  = $clog2(6);

  logic                 hold_s1, hold_s2, hold_prev;
  logic                 clr_s1, clr_s2;
  logic                 running_q, done_q;
  logic [DIV_W-1:0]     div_q;
  logic [MIN_W-1:0]     min_q;
  logic [SU_W-1:0]      sec_u;
  logic [ST_W-1:0]      sec_t;
  logic [SEG_OUT_W-1:0] seg1_q, seg2_q;
  logic [LED_W-1:0]     led_q;

  logic             hold_rise_c, clr_c, dir_c, tick_c;
  logic             hit_c, at_term_c, term_c, load_c;
  logic [MIN_W-1:0] term_min_c, reload_min_c;
  logic             u_inc_c, u_dec_c, u_wrap_c;
  logic             t_inc_c, t_dec_c, t_wrap_c;

  // Step qualification and terminal detection for the current value
  always_comb begin
    hold_rise_c  = hold_s2 & ~hold_prev;
    clr_c        = clr_s2;
    dir_c        = bus.dir;
    tick_c       = running_q && (div_q == DIV_W'(DIV - 1));
    term_min_c   = dir_c ? '0 : MIN_W'(MAX_MIN);
    reload_min_c = dir_c ? MIN_W'(MAX_MIN) : '0;
    at_term_c    = (sec_u == '0) && (sec_t == '0) && (min_q == term_min_c);
    hit_c        = 1'b0;
    if (dir_c) begin
      hit_c = (min_q == '0) && (sec_t == '0) && (sec_u == SU_W'(1));
    end else begin
      hit_c = (min_q == MIN_W'(MAX_MIN - 1)) && (sec_t == ST_W'(5)) && (sec_u == SU_W'(9));
    end
    // A tick while already at terminal (after a dir flip) is treated as reaching it
    term_c = tick_c && (hit_c || at_term_c);
    load_c = clr_c || term_c;
  end

  // Kept as separate assigns so the carry chain through the digits stays acyclic
  assign u_inc_c = tick_c && !dir_c && !term_c;
  assign u_dec_c = tick_c && dir_c && !term_c;
  assign t_inc_c = u_inc_c && u_wrap_c;
  assign t_dec_c = u_dec_c && u_wrap_c;

  bcd_digit #(.N(10)) u_sec_u (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .load_val   ('0),
    .inc        (u_inc_c),
    .dec        (u_dec_c),
    .q          (sec_u),
    .wrap_out_c (u_wrap_c)
  );

  bcd_digit #(.N(6)) u_sec_t (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .load_val   ('0),
    .inc        (t_inc_c),
    .dec        (t_dec_c),
    .q          (sec_t),
    .wrap_out_c (t_wrap_c)
  );

  // Two-flop button synchronisers plus hold edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_s1   <= 1'b0;
      hold_s2   <= 1'b0;
      hold_prev <= 1'b0;
      clr_s1    <= 1'b0;
      clr_s2    <= 1'b0;
    end else begin
      hold_s1   <= bus.hold;
      hold_s2   <= hold_s1;
      hold_prev <= hold_s2;
      clr_s1    <= bus.clear;
      clr_s2    <= clr_s1;
    end
  end

  // Tick divider, parked at zero whenever the timer is not counting
  always_ff @(posedge clk) begin
    if (rst || clr_c || !running_q || tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Minutes: loads on clear/terminal, otherwise follows tens-of-seconds carry/borrow
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
    end else if (clr_c) begin
      min_q <= reload_min_c;
    end else if (term_c) begin
      min_q <= WRAP ? reload_min_c : term_min_c;
    end else if (t_wrap_c && !dir_c) begin
      min_q <= min_q + MIN_W'(1);
    end else if (t_wrap_c && dir_c) begin
      min_q <= min_q - MIN_W'(1);
    end
  end

  // Run/stop control and the terminal pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= !clr_c && term_c;
      if (clr_c) begin
        running_q <= 1'b0;
      end else if (term_c && !WRAP) begin
        running_q <= 1'b0;
      end else if (hold_rise_c) begin
        if (running_q) begin
          running_q <= 1'b0;
        end else if (WRAP || !at_term_c) begin
          running_q <= 1'b1;
        end
      end
    end
  end

  // Display registers, one cycle behind the digit state
  always_ff @(posedge clk) begin
    if (rst) begin
      seg1_q <= {2'b00, SEG_0};
      seg2_q <= {2'b00, SEG_0};
      led_q  <= '1;
    end else begin
      seg1_q <= {2'b00, seg7_enc(4'(sec_t))};
      seg2_q <= {2'b00, seg7_enc(4'(sec_u))};
      for (int i = 0; i < int'(LED_W); i++) begin
        led_q[i] <= !(i < int'(min_q));
      end
    end
  end

  assign bus.seg_led_1 = seg1_q;
  assign bus.seg_led_2 = seg2_q;
  assign bus.led       = led_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_segment_timer.sv
// Bench for segment_timer: a stop-at-terminal and a wrapping instance share stimulus.
module tb_segment_timer;

  localparam int unsigned CLK_HZ  = 10;
  localparam int unsigned TICK_HZ = 1;
  localparam int unsigned MAX_MIN = 2;
  localparam int unsigned LED_W   = 8;
  localparam int          DIV     = 10;
  localparam int          TOP     = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic clear = 1'b0;
  logic dir = 1'b0;

  int total = 0;
  int bad   = 0;

  segment_timer_if #(.LED_W(LED_W)) bus0 ();
  segment_timer_if #(.LED_W(LED_W)) bus1 ();

  assign bus0.hold  = hold;
  assign bus0.clear = clear;
  assign bus0.dir   = dir;
  assign bus1.hold  = hold;
  assign bus1.clear = clear;
  assign bus1.dir   = dir;

  segment_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN), .LED_W(LED_W), .WRAP(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  segment_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN), .LED_W(LED_W), .WRAP(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  // Model state: the count is held as plain total seconds
  typedef struct packed {
    int         secs;
    bit         run;
    int         div;
    bit         done;
    logic [8:0] s1;
    logic [8:0] s2;
    logic [7:0] led;
  } mstate_t;

  mstate_t st0, st1;
  bit hs1, hs2, hprev, cs1, cs2;
  bit chk_en = 1'b0;

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_led(input int mins);
    logic [7:0] r;
    r = '1;
    for (int i = 0; i < 8; i++) if (i < mins) r[i] = 1'b0;
    return r;
  endfunction

  function automatic mstate_t reset_state();
    mstate_t r;
    r.secs = 0; r.run = 1'b0; r.div = 0; r.done = 1'b0;
    r.s1 = 9'h03F; r.s2 = 9'h03F; r.led = 8'hFF;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input bit wrap, input bit rise,
                                         input bit clr, input bit d);
    mstate_t n;
    int term_v, reload_v, step;
    bit at_term, tick, stopped;
    n        = s;
    term_v   = d ? 0 : TOP;
    reload_v = d ? TOP : 0;
    at_term  = (s.secs == term_v);
    tick     = s.run && (s.div == DIV - 1);
    stopped  = 1'b0;
    n.s1     = {2'b00, exp_seg((s.secs % 60) / 10)};
    n.s2     = {2'b00, exp_seg(s.secs % 10)};
    n.led    = exp_led(s.secs / 60);
    n.done   = 1'b0;
    if (clr) begin
      n.secs = reload_v;
      n.run  = 1'b0;
      n.div  = 0;
    end else begin
      n.div = (!s.run || tick) ? 0 : s.div + 1;
      if (tick) begin
        step = d ? s.secs - 1 : s.secs + 1;
        if (at_term || step == term_v) begin
          n.done = 1'b1;
          n.secs = wrap ? reload_v : term_v;
          if (!wrap) begin
            n.run   = 1'b0;
            stopped = 1'b1;
          end
        end else begin
          n.secs = step;
        end
      end
      if (rise && !stopped) begin
        if (s.run) n.run = 1'b0;
        else if (wrap || !at_term) n.run = 1'b1;
      end
    end
    return n;
  endfunction

  // Advance the model on every rising edge from the same sampled inputs the DUTs see
  always @(posedge clk) begin
    if (rst) begin
      chk_en <= 1'b1;
      st0    <= reset_state();
      st1    <= reset_state();
      hs1 <= 1'b0; hs2 <= 1'b0; hprev <= 1'b0; cs1 <= 1'b0; cs2 <= 1'b0;
    end else begin
      st0   <= model_next(st0, 1'b0, hs2 && !hprev, cs2, dir);
      st1   <= model_next(st1, 1'b1, hs2 && !hprev, cs2, dir);
      hs1   <= hold;
      hs2   <= hs1;
      hprev <= hs2;
      cs1   <= clear;
      cs2   <= cs1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0_seg1", 32'(bus0.seg_led_1), 32'(st0.s1));
      chk("m0_seg2", 32'(bus0.seg_led_2), 32'(st0.s2));
      chk("m0_led",  32'(bus0.led),       32'(st0.led));
      chk("m0_run",  32'(bus0.running),   32'(st0.run));
      chk("m0_done", 32'(bus0.done),      32'(st0.done));
      chk("m1_seg1", 32'(bus1.seg_led_1), 32'(st1.s1));
      chk("m1_seg2", 32'(bus1.seg_led_2), 32'(st1.s2));
      chk("m1_led",  32'(bus1.led),       32'(st1.led));
      chk("m1_run",  32'(bus1.running),   32'(st1.run));
      chk("m1_done", 32'(bus1.done),      32'(st1.done));
    end
  end

  // Hand-computed expectations for one instance
  task automatic chk_dut(input int which, input string tag, input logic [8:0] e1,
                         input logic [8:0] e2, input logic [7:0] el, input logic er,
                         input logic ed);
    if (which == 0) begin
      chk({tag, "_seg1"}, 32'(bus0.seg_led_1), 32'(e1));
      chk({tag, "_seg2"}, 32'(bus0.seg_led_2), 32'(e2));
      chk({tag, "_led"},  32'(bus0.led),       32'(el));
      chk({tag, "_run"},  32'(bus0.running),   32'(er));
      chk({tag, "_done"}, 32'(bus0.done),      32'(ed));
    end else begin
      chk({tag, "_seg1"}, 32'(bus1.seg_led_1), 32'(e1));
      chk({tag, "_seg2"}, 32'(bus1.seg_led_2), 32'(e2));
      chk({tag, "_led"},  32'(bus1.led),       32'(el));
      chk({tag, "_run"},  32'(bus1.running),   32'(er));
      chk({tag, "_done"}, 32'(bus1.done),      32'(ed));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(output logic sig_unused);
    sig_unused = 1'b0;
  endtask

  initial begin
    logic dummy;
    // 1: reset
    cyc(2);
    chk_dut(0, "t1_rst", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    chk_dut(1, "t1_rst1", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;

    // 2: start counting up
    hold = 1'b1;
    cyc(2);
    chk("t2_run_early", 32'(bus0.running), 32'd0);
    cyc(1);
    chk("t2_run", 32'(bus0.running), 32'd1);
    hold = 1'b0;
    cyc(10);
    chk_dut(0, "t2_pre", 9'h03F, 9'h03F, 8'hFF, 1'b1, 1'b0);
    cyc(1);
    chk_dut(0, "t2_one", 9'h03F, 9'h006, 8'hFF, 1'b1, 1'b0);

    // 3: 0:59 -> 1:00
    cyc(589);
    chk_dut(0, "t3_059", 9'h06D, 9'h06F, 8'hFF, 1'b1, 1'b0);
    cyc(1);
    chk_dut(0, "t3_100", 9'h03F, 9'h03F, 8'hFE, 1'b1, 1'b0);

    // 4: terminal at 2:00
    cyc(598);
    chk("t4_done_pre", 32'(bus0.done), 32'd0);
    cyc(1);
    chk("t4_done0", 32'(bus0.done), 32'd1);
    chk("t4_run0", 32'(bus0.running), 32'd0);
    chk("t4_done1", 32'(bus1.done), 32'd1);
    chk("t4_run1", 32'(bus1.running), 32'd1);
    cyc(1);
    chk_dut(0, "t4_hold0", 9'h03F, 9'h03F, 8'hFC, 1'b0, 1'b0);
    chk_dut(1, "t4_wrap1", 9'h03F, 9'h03F, 8'hFF, 1'b1, 1'b0);
    hold = 1'b1;
    cyc(3);
    hold = 1'b0;
    cyc(6);
    chk_dut(0, "t4_ign", 9'h03F, 9'h03F, 8'hFC, 1'b0, 1'b0);
    chk("t4_stop1", 32'(bus1.running), 32'd0);

    // 5: count down from 2:00
    dir = 1'b1;
    clear = 1'b1;
    cyc(2);
    clear = 1'b0;
    cyc(5);
    chk_dut(0, "t5_load", 9'h03F, 9'h03F, 8'hFC, 1'b0, 1'b0);
    hold = 1'b1;
    cyc(3);
    chk("t5_run", 32'(bus0.running), 32'd1);
    hold = 1'b0;
    cyc(10);
    chk_dut(0, "t5_pre", 9'h03F, 9'h03F, 8'hFC, 1'b1, 1'b0);
    cyc(1);
    chk_dut(0, "t5_159", 9'h06D, 9'h06F, 8'hFE, 1'b1, 1'b0);
    cyc(1188);
    chk("t5_done_pre", 32'(bus0.done), 32'd0);
    cyc(1);
    chk("t5_done0", 32'(bus0.done), 32'd1);
    chk("t5_run0", 32'(bus0.running), 32'd0);
    chk("t5_done1", 32'(bus1.done), 32'd1);
    chk("t5_run1", 32'(bus1.running), 32'd1);
    cyc(1);
    chk_dut(0, "t5_zero0", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    chk_dut(1, "t5_wrap1", 9'h03F, 9'h03F, 8'hFC, 1'b1, 1'b0);

    // 6: clear together with hold_rise on a tick, then reset mid-count
    dir = 1'b0;
    clear = 1'b1;
    cyc(2);
    clear = 1'b0;
    cyc(5);
    hold = 1'b1;
    cyc(3);
    chk("t6_run", 32'(bus0.running), 32'd1);
    hold = 1'b0;
    cyc(17);
    hold = 1'b1;
    clear = 1'b1;
    cyc(1);
    hold = 1'b0;
    clear = 1'b0;
    cyc(1);
    chk_dut(0, "t6_pre", 9'h03F, 9'h006, 8'hFF, 1'b1, 1'b0);
    cyc(1);
    chk("t6_run_off", 32'(bus0.running), 32'd0);
    chk("t6_no_done", 32'(bus0.done), 32'd0);
    cyc(1);
    chk_dut(0, "t6_clr0", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    chk_dut(1, "t6_clr1", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    hold = 1'b1;
    cyc(3);
    hold = 1'b0;
    cyc(15);
    chk("t6_mid", 32'(bus0.seg_led_2), 32'h006);
    rst = 1'b1;
    cyc(1);
    chk_dut(0, "t6_rst0", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    chk_dut(1, "t6_rst1", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(20);
    chk_dut(0, "t6_idle", 9'h03F, 9'h03F, 8'hFF, 1'b0, 1'b0);
    pulse(dummy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
